// File: rtl/pfd_tdc_5bit_pkg.sv
// Shared ADPLL definitions for the phase/frequency detector and the loop filter.
//   ERR_MAG_W   : width of the sign-magnitude error magnitude (adder/subtractor operand)
//   ERR_MAG_MAX : largest representable error magnitude
//   pfd_state_e : detector FSM states
package pfd_tdc_5bit_pkg;

    localparam int unsigned ERR_MAG_W   = 5;
    localparam int unsigned ERR_MAG_MAX = 31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } pfd_state_e;

endpackage

// File: rtl/pfd_tdc_5bit_sync_rise_det.sv
// Multi-flop synchronizer followed by a registered rising-edge pulse.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   din   : asynchronous input level
//   rise  : one-cycle pulse, registered, for each synchronized rising edge of din
module sync_rise_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/pfd_tdc_5bit.sv
// Counter-based phase/frequency detector and time-to-digital converter.
// Timestamps rising edges of ref_in and fb_in in clk cycles and emits one
// sign-magnitude phase error per comparison.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : detector enable; low forces IDLE and drops any open measurement
//   ref_in     : reference clock (asynchronous)
//   fb_in      : divided DCO feedback clock (asynchronous)
//   err_mag    : error magnitude in clk cycles, saturated at 2^MAG_W-1
//   err_sign   : 0 = feedback lags (ref first), 1 = feedback leads
//   err_valid  : one-cycle strobe marking a new err_mag/err_sign
//   slip       : one-cycle strobe with err_valid on a saturated result
module pfd_tdc_5bit
    import pfd_tdc_5bit_pkg::*;
#(
    parameter int unsigned MAG_W       = ERR_MAG_W,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic [MAG_W-1:0] err_mag,
    output logic             err_sign,
    output logic             err_valid,
    output logic             slip
);

    localparam logic [MAG_W-1:0] MAG_SAT      = '1;
    localparam logic [CNT_W:0]   MAG_SAT_WIDE = {{(CNT_W + 1 - MAG_W){1'b0}}, MAG_SAT};
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT);

    logic ref_edge;
    logic fb_edge;

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ref_det (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ref_in),
        .rise (ref_edge)
    );

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fb_det (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (fb_in),
        .rise (fb_edge)
    );

    pfd_state_e       state;
    logic [CNT_W-1:0] cnt;

    // cnt holds k-1 in the cycle the opposite edge is seen, so the interval is cnt+1.
    logic [CNT_W:0]   interval;
    logic             interval_over;
    logic [MAG_W-1:0] interval_mag;
    logic             lead_sign;
    logic             opp_edge;
    logic             same_edge;

    always_comb begin
        interval      = {1'b0, cnt} + 1'b1;
        interval_over = interval > MAG_SAT_WIDE;
        interval_mag  = interval_over ? MAG_SAT : interval[MAG_W-1:0];
        lead_sign     = (state == FB_LEAD);
        opp_edge      = lead_sign ? ref_edge : fb_edge;
        same_edge     = lead_sign ? fb_edge : ref_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            err_mag   <= '0;
            err_sign  <= 1'b0;
            err_valid <= 1'b0;
            slip      <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            slip      <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (ref_edge && fb_edge) begin
                            err_valid <= 1'b1;
                            err_mag   <= '0;
                            err_sign  <= 1'b0;
                        end else if (ref_edge) begin
                            state <= REF_LEAD;
                        end else if (fb_edge) begin
                            state <= FB_LEAD;
                        end
                    end
                    REF_LEAD, FB_LEAD: begin
                        if (opp_edge) begin
                            // Opposite edge wins over a simultaneous same edge.
                            err_valid <= 1'b1;
                            err_mag   <= interval_mag;
                            err_sign  <= lead_sign;
                            slip      <= interval_over;
                            state     <= IDLE;
                            cnt       <= '0;
                        end else if (same_edge) begin
                            // Cycle slip: report saturated, restart timing from the new edge.
                            err_valid <= 1'b1;
                            err_mag   <= MAG_SAT;
                            err_sign  <= lead_sign;
                            slip      <= 1'b1;
                            cnt       <= '0;
                        end else if (cnt == TIMEOUT_CNT) begin
                            err_valid <= 1'b1;
                            err_mag   <= MAG_SAT;
                            err_sign  <= lead_sign;
                            slip      <= 1'b1;
                            state     <= IDLE;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pfd_tdc_5bit.sv
// Directed self-checking bench for pfd_tdc_5bit.
module tb_pfd_tdc_5bit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ref_in;
    logic       fb_in;
    logic [4:0] err_mag;
    logic       err_sign;
    logic       err_valid;
    logic       slip;

    int tests;
    int fails;
    int cyc;
    int nval;
    int last_mag;
    int last_sign;
    int last_slip;
    int last_cyc;

    pfd_tdc_5bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ref_in   (ref_in),
        .fb_in    (fb_in),
        .err_mag  (err_mag),
        .err_sign (err_sign),
        .err_valid(err_valid),
        .slip     (slip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe seen at the falling edge.
    initial nval = 0;
    always @(negedge clk) begin
        if (err_valid) begin
            nval      <= nval + 1;
            last_mag  <= int'(err_mag);
            last_sign <= int'(err_sign);
            last_slip <= int'(slip);
            last_cyc  <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // First edge, then the opposite edge k cycles later (k == 0: simultaneous).
    task automatic pair(input string tag, input bit ref_first, input int k, input int exp_mag,
                        input int exp_sign, input int exp_slip);
        int nv0;
        int t2;
        nv0 = nval;
        if (k == 0) begin
            ref_in = 1'b1;
            fb_in  = 1'b1;
            t2     = cyc;
            tick(2);
            ref_in = 1'b0;
            fb_in  = 1'b0;
        end else begin
            if (ref_first) ref_in = 1'b1;
            else fb_in = 1'b1;
            tick(2);
            ref_in = 1'b0;
            fb_in  = 1'b0;
            tick(k - 2);
            if (ref_first) fb_in = 1'b1;
            else ref_in = 1'b1;
            t2 = cyc;
            tick(2);
            ref_in = 1'b0;
            fb_in  = 1'b0;
        end
        tick(6);
        chk({tag, "_count"}, nval - nv0, 1);
        chk({tag, "_latency"}, last_cyc - t2, 4);
        chk({tag, "_mag"}, last_mag, exp_mag);
        chk({tag, "_sign"}, last_sign, exp_sign);
        chk({tag, "_slip"}, last_slip, exp_slip);
        chk({tag, "_valid_low"}, int'(err_valid), 0);
        chk({tag, "_mag_hold"}, int'(err_mag), exp_mag);
    endtask

    initial begin
        int nv0;
        int t_r2;
        int t_fb;
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        tick(3);
        chk("rst_mag", int'(err_mag), 0);
        chk("rst_sign", int'(err_sign), 0);
        chk("rst_valid", int'(err_valid), 0);
        chk("rst_slip", int'(slip), 0);
        rst_n = 1'b1;
        tick(5);

        pair("ref5", 1'b1, 5, 5, 0, 0);
        pair("same", 1'b1, 0, 0, 0, 0);
        pair("ref31", 1'b1, 31, 31, 0, 0);
        pair("ref40", 1'b1, 40, 31, 0, 1);
        pair("ref32", 1'b1, 32, 31, 0, 1);

        // Two ref edges 20 apart, then fb 3 after the second.
        nv0    = nval;
        ref_in = 1'b1;
        tick(2);
        ref_in = 1'b0;
        tick(18);
        ref_in = 1'b1;
        t_r2   = cyc;
        tick(2);
        ref_in = 1'b0;
        tick(1);
        fb_in = 1'b1;
        t_fb  = cyc;
        tick(2);
        fb_in = 1'b0;
        tick(1);
        chk("slip1_count", nval - nv0, 1);
        chk("slip1_cyc", last_cyc - t_r2, 4);
        chk("slip1_mag", last_mag, 31);
        chk("slip1_sign", last_sign, 0);
        chk("slip1_slip", last_slip, 1);
        tick(4);
        chk("slip2_count", nval - nv0, 2);
        chk("slip2_cyc", last_cyc - t_fb, 4);
        chk("slip2_mag", last_mag, 3);
        chk("slip2_sign", last_sign, 0);
        chk("slip2_slip", last_slip, 0);

        // Lone ref edge: timeout once counter sits at 63.
        nv0    = nval;
        ref_in = 1'b1;
        t_r2   = cyc;
        tick(2);
        ref_in = 1'b0;
        tick(70);
        chk("tmo_count", nval - nv0, 1);
        chk("tmo_cyc", last_cyc - t_r2, 68);
        chk("tmo_mag", last_mag, 31);
        chk("tmo_sign", last_sign, 0);
        chk("tmo_slip", last_slip, 1);

        pair("fb12", 1'b0, 12, 12, 1, 0);

        // Reset in the middle of a measurement.
        nv0    = nval;
        ref_in = 1'b1;
        tick(2);
        ref_in = 1'b0;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mag", int'(err_mag), 0);
        chk("mid_rst_sign", int'(err_sign), 0);
        tick(2);
        chk("mid_rst_valid", int'(err_valid), 0);
        rst_n = 1'b1;
        tick(1);
        fb_in = 1'b1;
        t_fb  = cyc;
        tick(2);
        fb_in = 1'b0;
        tick(16);
        chk("post_rst_count", nval - nv0, 0);
        chk("post_rst_mag", int'(err_mag), 0);
        chk("post_rst_sign", int'(err_sign), 0);
        chk("post_rst_slip", int'(slip), 0);
        // The lone fb edge after reset opens a fresh measurement that times out.
        tick(55);
        chk("fb_tmo_count", nval - nv0, 1);
        chk("fb_tmo_cyc", last_cyc - t_fb, 68);
        chk("fb_tmo_mag", last_mag, 31);
        chk("fb_tmo_sign", last_sign, 1);
        chk("fb_tmo_slip", last_slip, 1);

        // Enable dropped in the middle of a measurement; fb arrives while disabled.
        nv0    = nval;
        ref_in = 1'b1;
        tick(2);
        ref_in = 1'b0;
        tick(3);
        en = 1'b0;
        tick(1);
        fb_in = 1'b1;
        tick(2);
        fb_in = 1'b0;
        tick(6);
        en = 1'b1;
        tick(10);
        chk("en_drop_count", nval - nv0, 0);

        pair("fb7", 1'b0, 7, 7, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
